// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller.
// Holds the command opcode set, the controller state encoding, the bundle
// of registered control outputs and the legal round-count check.
package aes_pkg;

  // Round counts of the three AES key sizes
  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  // Command set: single-step ops plus full multi-round encryption
  typedef enum logic [2:0] {
    NOOP            = 3'd0,
    AESENC          = 3'd1,
    AESENCLAST      = 3'd2,
    AESKEYGENASSIST = 3'd3,
    AESENCFULL      = 3'd4
  } opcode;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ZERO = 3'd1,
    ST_SUB  = 3'd2,
    ST_RND  = 3'd3,
    ST_LAST = 3'd4,
    ST_KEY  = 3'd5,
    ST_DONE = 3'd6
  } ctrl_state_t;

  // Control outputs driven to aes_enc / key_gen, registered as one bundle
  typedef struct packed {
    logic idle;
    logic full_enc;
    logic zero_rnd;
    logic key_sel;
    logic final_rnd;
    logic key_sub;
    logic gen_key;
    logic r_con_ctrl;
    logic next_rnd;
    logic cipher_ready;
    logic key_ready;
  } ctrl_out_t;

  // Output bundle seen while idle (and straight out of reset)
  localparam ctrl_out_t CTRL_OUT_IDLE = '{idle: 1'b1, default: 1'b0};

  // A full encryption is only started for a real AES round count that the
  // instance is built to handle.
  function automatic logic nr_legal(input logic [31:0] nr, input logic [31:0] nr_max);
    logic known;
    known = (nr == 32'(NR_AES128)) || (nr == 32'(NR_AES192)) || (nr == 32'(NR_AES256));
    return known && (nr <= nr_max);
  endfunction

endpackage

// File: rtl/aes_rnd_cnt.sv
// Round counter for the AES round controller.
// Clear has priority over increment; the count saturates instead of wrapping.
// last_o flags that the current round is the next-to-final one (cnt == nr-1),
// which tells the controller the following SUB leads into the LAST round.
module aes_rnd_cnt #(
  parameter int RND_W = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [RND_W-1:0] nr_i,
  output logic [RND_W-1:0] cnt_o,
  output logic             last_o
);

  logic [RND_W-1:0] cnt_r;

  // Round count register: synchronous reset, clear, saturating increment
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_r <= {RND_W{1'b0}};
    end else if (clr_i) begin
      cnt_r <= {RND_W{1'b0}};
    end else if (inc_i && (cnt_r != {RND_W{1'b1}})) begin
      cnt_r <= cnt_r + RND_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_o  = cnt_r;
  assign last_o = (cnt_r == (nr_i - RND_W'(1)));

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round controller: sequences AESENC, AESENCLAST, AESKEYGENASSIST and
// full AES-128/192/256 encryption (AESENCFULL), driving aes_enc and key_gen.
// All outputs are registered; they are decoded from the next state so the
// registered value always matches the state the controller is in.
// Optional build macro AES_CTRL_ABORT_EN adds abort_i, which returns any
// running operation to IDLE without a completion pulse.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR_MAX = 14,
  parameter int RND_W  = $clog2(NR_MAX + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start_i,
  input  opcode            opcode_i,
  input  logic [RND_W-1:0] nr_i,
`ifdef AES_CTRL_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             idle_o,
  output logic             full_enc_o,
  output logic             zero_rnd_o,
  output logic             key_sel_o,
  output logic             final_rnd_o,
  output logic             key_sub_o,
  output logic             gen_key_o,
  output logic             r_con_ctrl_o,
  output logic             next_rnd_o,
  output logic [RND_W-1:0] round_o,
  output logic             cipher_ready_o,
  output logic             key_ready_o,
  output logic             err_o
);

  ctrl_state_t      state_r, state_nxt_s;
  opcode            op_r, op_nxt_s;
  logic [RND_W-1:0] nr_r;
  logic             fin_r, fin_nxt_s;
  ctrl_out_t        out_r, out_nxt_s;
  logic             err_r, err_nxt_s;
  logic             abort_s;
  logic             accept_s;
  logic             nr_ok_s;
  logic             is_full_s;
  logic             cnt_clr_s;
  logic             cnt_inc_s;
  logic             cnt_last_s;
  logic [RND_W-1:0] cnt_s;

  // Abort request, tied off when the abort feature is not built
  always_comb begin
`ifdef AES_CTRL_ABORT_EN
    abort_s = abort_i;
`else
    abort_s = 1'b0;
`endif
  end

  assign nr_ok_s = nr_legal(32'(nr_i), 32'(NR_MAX));

  // Next-state logic; fin tracks that the upcoming SUB belongs to the final round
  always_comb begin
    state_nxt_s = state_r;
    fin_nxt_s   = fin_r;
    err_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        fin_nxt_s = 1'b0;
        if (start_i) begin
          case (opcode_i)
            AESENC, AESENCLAST: state_nxt_s = ST_SUB;
            AESKEYGENASSIST:    state_nxt_s = ST_KEY;
            AESENCFULL: begin
              if (nr_ok_s) begin
                state_nxt_s = ST_ZERO;
              end else begin
                state_nxt_s = ST_IDLE;
                err_nxt_s   = 1'b1;
              end
            end
            default: state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ZERO: state_nxt_s = ST_SUB;
      ST_SUB: begin
        if (op_r == AESENCFULL) begin
          state_nxt_s = fin_r ? ST_LAST : ST_RND;
        end else if (op_r == AESENCLAST) begin
          state_nxt_s = ST_LAST;
        end else begin
          state_nxt_s = ST_RND;
        end
      end
      ST_RND: begin
        if (op_r == AESENCFULL) begin
          state_nxt_s = ST_SUB;
          fin_nxt_s   = cnt_last_s;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_LAST: state_nxt_s = ST_DONE;
      ST_KEY:  state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
    if (abort_s && (state_r != ST_IDLE)) begin
      state_nxt_s = ST_IDLE;
      fin_nxt_s   = 1'b0;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  assign accept_s  = (state_r == ST_IDLE) && (state_nxt_s != ST_IDLE);
  assign op_nxt_s  = accept_s ? opcode_i : op_r;
  assign is_full_s = (op_nxt_s == AESENCFULL);

  // Round counter steps on entry to SUB/KEY and clears whenever IDLE is entered
  assign cnt_clr_s = (state_nxt_s == ST_IDLE);
  assign cnt_inc_s = (state_nxt_s == ST_SUB) || (state_nxt_s == ST_KEY);

  aes_rnd_cnt #(
    .RND_W (RND_W)
  ) u_rnd_cnt (
    .clk    (clk),
    .nrst   (nrst),
    .clr_i  (cnt_clr_s),
    .inc_i  (cnt_inc_s),
    .nr_i   (nr_r),
    .cnt_o  (cnt_s),
    .last_o (cnt_last_s)
  );

  // Moore output decode of the state being entered, for registering
  always_comb begin
    out_nxt_s = '0;
    case (state_nxt_s)
      ST_IDLE: out_nxt_s.idle = 1'b1;
      ST_ZERO: begin
        out_nxt_s.zero_rnd   = 1'b1;
        out_nxt_s.r_con_ctrl = 1'b1;
      end
      ST_SUB:  out_nxt_s.key_sub = 1'b0;
      ST_RND: begin
        out_nxt_s.full_enc = 1'b1;
        out_nxt_s.key_sel  = is_full_s;
        out_nxt_s.next_rnd = is_full_s;
        out_nxt_s.gen_key  = is_full_s;
      end
      ST_LAST: begin
        out_nxt_s.final_rnd = 1'b1;
        out_nxt_s.key_sel   = is_full_s;
        out_nxt_s.gen_key   = is_full_s;
      end
      ST_KEY: begin
        out_nxt_s.key_sub = 1'b1;
        out_nxt_s.gen_key = 1'b1;
      end
      ST_DONE: begin
        if (op_nxt_s == AESKEYGENASSIST) begin
          out_nxt_s.key_ready = 1'b1;
        end else begin
          out_nxt_s.cipher_ready = 1'b1;
        end
      end
      default: out_nxt_s = CTRL_OUT_IDLE;
    endcase
  end

  // State, latched command and registered outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r <= ST_IDLE;
      op_r    <= NOOP;
      nr_r    <= {RND_W{1'b0}};
      fin_r   <= 1'b0;
      out_r   <= CTRL_OUT_IDLE;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      op_r    <= op_nxt_s;
      nr_r    <= accept_s ? nr_i : nr_r;
      fin_r   <= fin_nxt_s;
      out_r   <= out_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign idle_o         = out_r.idle;
  assign full_enc_o     = out_r.full_enc;
  assign zero_rnd_o     = out_r.zero_rnd;
  assign key_sel_o      = out_r.key_sel;
  assign final_rnd_o    = out_r.final_rnd;
  assign key_sub_o      = out_r.key_sub;
  assign gen_key_o      = out_r.gen_key;
  assign r_con_ctrl_o   = out_r.r_con_ctrl;
  assign next_rnd_o     = out_r.next_rnd;
  assign cipher_ready_o = out_r.cipher_ready;
  assign key_ready_o    = out_r.key_ready;
  assign err_o          = err_r;
  assign round_o        = cnt_s;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl. Each command is turned into the
// expected cycle-by-cycle output schedule (built directly from the round
// structure of the operation) and compared against the DUT every cycle.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam int RW = 4;

  typedef struct packed {
    logic          idle;
    logic          full_enc;
    logic          zero_rnd;
    logic          key_sel;
    logic          final_rnd;
    logic          key_sub;
    logic          gen_key;
    logic          r_con;
    logic          next_rnd;
    logic          cipher_ready;
    logic          key_ready;
    logic          err;
    logic [RW-1:0] rnd;
  } ovec_t;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start_i;
  opcode         opcode_i;
  logic [RW-1:0] nr_i;
  logic          abort_i;
  logic idle_o, full_enc_o, zero_rnd_o, key_sel_o, final_rnd_o, key_sub_o;
  logic gen_key_o, r_con_ctrl_o, next_rnd_o, cipher_ready_o, key_ready_o, err_o;
  logic [RW-1:0] round_o;

  int checks   = 0;
  int failures = 0;
  ovec_t exp_q[$];
  ovec_t obs;

  aes_round_ctrl #(.NR_MAX(14)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .start_i        (start_i),
    .opcode_i       (opcode_i),
    .nr_i           (nr_i),
`ifdef AES_CTRL_ABORT_EN
    .abort_i        (abort_i),
`endif
    .idle_o         (idle_o),
    .full_enc_o     (full_enc_o),
    .zero_rnd_o     (zero_rnd_o),
    .key_sel_o      (key_sel_o),
    .final_rnd_o    (final_rnd_o),
    .key_sub_o      (key_sub_o),
    .gen_key_o      (gen_key_o),
    .r_con_ctrl_o   (r_con_ctrl_o),
    .next_rnd_o     (next_rnd_o),
    .round_o        (round_o),
    .cipher_ready_o (cipher_ready_o),
    .key_ready_o    (key_ready_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  assign obs = {idle_o, full_enc_o, zero_rnd_o, key_sel_o, final_rnd_o, key_sub_o,
                gen_key_o, r_con_ctrl_o, next_rnd_o, cipher_ready_o, key_ready_o,
                err_o, round_o};

  function automatic ovec_t v_idle();
    ovec_t v;
    v = '0;
    v.idle = 1'b1;
    return v;
  endfunction

  function automatic ovec_t v_rnd(input int r);
    ovec_t v;
    v = '0;
    v.rnd = RW'(r);
    return v;
  endfunction

  task automatic chk(input string tag, input ovec_t expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, expv);
    end
  endtask

  // Expected outputs for cycles k+1.. after a command accepted at posedge k
  task automatic build(input opcode op, input int nr);
    ovec_t v;
    exp_q.delete();
    case (op)
      AESENC, AESENCLAST: begin
        exp_q.push_back(v_rnd(1));
        v = v_rnd(1);
        if (op == AESENC) v.full_enc = 1'b1;
        else v.final_rnd = 1'b1;
        exp_q.push_back(v);
        v = v_rnd(1); v.cipher_ready = 1'b1; exp_q.push_back(v);
      end
      AESKEYGENASSIST: begin
        v = v_rnd(1); v.key_sub = 1'b1; v.gen_key = 1'b1; exp_q.push_back(v);
        v = v_rnd(1); v.key_ready = 1'b1; exp_q.push_back(v);
      end
      AESENCFULL: begin
        if (nr == 10 || nr == 12 || nr == 14) begin
          v = v_rnd(0); v.zero_rnd = 1'b1; v.r_con = 1'b1; exp_q.push_back(v);
          for (int r = 1; r < nr; r++) begin
            exp_q.push_back(v_rnd(r));
            v = v_rnd(r);
            v.full_enc = 1'b1; v.key_sel = 1'b1; v.next_rnd = 1'b1; v.gen_key = 1'b1;
            exp_q.push_back(v);
          end
          exp_q.push_back(v_rnd(nr));
          v = v_rnd(nr); v.final_rnd = 1'b1; v.key_sel = 1'b1; v.gen_key = 1'b1;
          exp_q.push_back(v);
          v = v_rnd(nr); v.cipher_ready = 1'b1; exp_q.push_back(v);
        end else begin
          v = v_idle(); v.err = 1'b1; exp_q.push_back(v);
        end
      end
      default: exp_q.push_back(v_idle());
    endcase
  endtask

  // While busy: mode 0 keeps start low, 1 drives random noise, 2 holds AESENC
  task automatic busy_drive(input int mode);
    case (mode)
      1: begin
        start_i  = 1'($urandom_range(0, 1));
        opcode_i = opcode'($urandom_range(0, 4));
        nr_i     = RW'($urandom_range(0, 15));
      end
      2: begin
        start_i  = 1'b1;
        opcode_i = AESENC;
      end
      default: start_i = 1'b0;
    endcase
  endtask

  // Issue one command and check every cycle until the controller is idle again
  task automatic run_cmd(input string tag, input opcode op, input int nr, input int mode);
    build(op, nr);
    start_i  = 1'b1;
    opcode_i = op;
    nr_i     = RW'(nr);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      chk(tag, exp_q[i]);
      if (!exp_q[i].idle) busy_drive(mode);
      else start_i = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, "_idle"}, v_idle());
    start_i = 1'b0;
  endtask

  initial begin
    int pick;
    int nr;
    opcode op;
    nrst = 1'b0; start_i = 1'b0; opcode_i = NOOP; nr_i = '0; abort_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; opcode_i = AESENCFULL; nr_i = 4'd10;
    @(posedge clk); #1;
    chk("reset", v_idle());
    start_i = 1'b0;
    nrst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset", v_idle());

    run_cmd("enc",       AESENC,          0,  0);
    run_cmd("enclast",   AESENCLAST,      0,  0);
    run_cmd("full10",    AESENCFULL,      10, 0);
    run_cmd("full14",    AESENCFULL,      14, 0);
    run_cmd("full12",    AESENCFULL,      12, 0);
    run_cmd("bad_nr11",  AESENCFULL,      11, 0);
    run_cmd("bad_nr0",   AESENCFULL,      0,  0);
    run_cmd("keygen",    AESKEYGENASSIST, 0,  0);
    run_cmd("noop",      NOOP,            0,  0);
    run_cmd("full_hold", AESENCFULL,      10, 2);
    run_cmd("back2back", AESENC,          0,  0);

    // Synchronous reset in the middle of a full encryption
    build(AESENCFULL, 10);
    start_i = 1'b1; opcode_i = AESENCFULL; nr_i = 4'd10;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("pre_rst", exp_q[i]);
      start_i = 1'b0;
    end
    nrst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst", v_idle());
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("after_rst", v_idle());
    end

`ifdef AES_CTRL_ABORT_EN
    // Abort at k+7 of a full encryption
    build(AESENCFULL, 10);
    start_i = 1'b1; opcode_i = AESENCFULL; nr_i = 4'd10;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("pre_abort", exp_q[i]);
      start_i = 1'b0;
    end
    abort_i = 1'b1; start_i = 1'b1; opcode_i = AESENC;
    @(posedge clk); #1;
    chk("abort", v_idle());
    abort_i = 1'b0; start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("after_abort", v_idle());
    end
    abort_i = 1'b1;
    run_cmd("abort_idle_enc", AESENC, 0, 0);
    abort_i = 1'b0;
`endif

    // Randomised command stream with random noise on start while busy
    for (int n = 0; n < 40; n++) begin
      op   = opcode'($urandom_range(0, 4));
      pick = $urandom_range(0, 3);
      nr   = (pick == 0) ? 10 : (pick == 1) ? 12 : (pick == 2) ? 14 : $urandom_range(0, 15);
      run_cmd("rand", op, nr, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
